// File: rtl/adt7420_temp_proc.sv
`default_nettype none
// ============================================================================
// Module   : adt7420_temp_proc
// Brief    : ADT7420 TempReg post-processor: moving average, min/max, count,
//            hysteretic alarm and LED readout of the averaged temperature.
// Revision : 1.0 - initial release
// ============================================================================
module adt7420_temp_proc #(
  parameter int AVG_LOG2 = 3,
  parameter int DATA_W   = 13
) (
  input  logic                     FSM_Clk,
  input  logic                     rst_n,
  input  logic                     temp_valid,
  input  logic [15:0]              TempReg,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] t_high,
  input  logic [7:0]               t_hyst,
  output logic signed [DATA_W-1:0] temp_c,
  output logic signed [DATA_W-1:0] temp_avg,
  output logic signed [DATA_W-1:0] temp_min,
  output logic signed [DATA_W-1:0] temp_max,
  output logic [15:0]              sample_count,
  output logic                     alarm,
  output logic                     overrun,
  output logic                     out_valid,
  output logic [7:0]               led
);

  localparam int c_DEPTH = 1 << AVG_LOG2;
  localparam int c_PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int c_BUF_N = 1 << c_PTR_W;
  localparam int c_SUM_W = DATA_W + AVG_LOG2;
  localparam logic [c_PTR_W-1:0]       c_PTR_LAST = c_PTR_W'(c_DEPTH - 1);
  localparam logic signed [DATA_W-1:0] c_MIN_INIT = 13'h0FFF;
  localparam logic signed [DATA_W-1:0] c_MAX_INIT = 13'h1000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_UPDATE  = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  state_t                    r_state;
  logic signed [DATA_W-1:0]  r_buf [c_BUF_N];
  logic signed [c_SUM_W-1:0] r_sum;
  logic [c_PTR_W-1:0]        r_wr_ptr;
  logic                      r_first;

  logic signed [DATA_W-1:0]  w_raw;
  logic                      w_unused_lsbs;
  logic signed [c_SUM_W-1:0] w_sample_ext;
  logic signed [c_SUM_W-1:0] w_old_ext;
  logic signed [DATA_W-1:0]  w_avg;
  logic signed [DATA_W:0]    w_avg_ext;
  logic signed [DATA_W:0]    w_clr_thr;

  assign w_raw         = TempReg[15:3];
  assign w_unused_lsbs = ^TempReg[2:0];
  assign w_sample_ext  = c_SUM_W'(temp_c);
  assign w_old_ext     = c_SUM_W'(r_buf[r_wr_ptr]);
  assign w_avg         = DATA_W'(r_sum >>> AVG_LOG2);
  assign w_avg_ext     = {w_avg[DATA_W-1], w_avg};
  // Threshold is one bit wider so t_high - t_hyst cannot wrap near -4096.
  assign w_clr_thr     = {t_high[DATA_W-1], t_high} - {{(DATA_W-7){1'b0}}, t_hyst};

  always_ff @(posedge FSM_Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sum        <= '0;
      r_wr_ptr     <= '0;
      r_first      <= 1'b1;
      temp_c       <= '0;
      temp_avg     <= '0;
      temp_min     <= c_MIN_INIT;
      temp_max     <= c_MAX_INIT;
      sample_count <= '0;
      alarm        <= 1'b0;
      overrun      <= 1'b0;
      out_valid    <= 1'b0;
      led          <= '0;
      for (int i = 0; i < c_BUF_N; i++) r_buf[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        temp_min     <= c_MIN_INIT;
        temp_max     <= c_MAX_INIT;
        sample_count <= '0;
        overrun      <= 1'b0;
        r_first      <= 1'b1;
        if (r_state == S_IDLE && temp_valid) begin
          temp_c  <= w_raw;
          r_state <= S_UPDATE;
        end else begin
          r_state <= S_IDLE;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (temp_valid) begin
              temp_c  <= w_raw;
              r_state <= S_UPDATE;
            end
          end
          S_UPDATE: begin
            if (temp_valid) overrun <= 1'b1;
            // Prefilling the window makes the first average equal the first sample.
            if (r_first) begin
              for (int i = 0; i < c_BUF_N; i++) r_buf[i] <= temp_c;
              r_sum   <= w_sample_ext <<< AVG_LOG2;
              r_first <= 1'b0;
            end else begin
              r_buf[r_wr_ptr] <= temp_c;
              r_sum           <= r_sum - w_old_ext + w_sample_ext;
              r_wr_ptr        <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (temp_c < temp_min) temp_min <= temp_c;
            if (temp_c > temp_max) temp_max <= temp_c;
            if (sample_count != 16'hFFFF) sample_count <= sample_count + 16'd1;
            r_state <= S_PUBLISH;
          end
          S_PUBLISH: begin
            if (temp_valid) overrun <= 1'b1;
            temp_avg  <= w_avg;
            led       <= w_avg[11:4];
            if (w_avg > t_high)              alarm <= 1'b1;
            else if (w_avg_ext < w_clr_thr)  alarm <= 1'b0;
            out_valid <= 1'b1;
            r_state   <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adt7420_temp_proc.sv
`default_nettype none
// ============================================================================
// Module   : tb_adt7420_temp_proc
// Brief    : Bench for adt7420_temp_proc; drives depth-8 and depth-1 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adt7420_temp_proc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, temp_valid, clear;
  logic [15:0]        TempReg;
  logic signed [12:0] t_high;
  logic [7:0]         t_hyst;

  logic signed [12:0] c3, a3, mn3, mx3, c0, a0, mn0, mx0;
  logic [15:0]        n3, n0;
  logic               al3, al0, ov3, ov0, v3, v0;
  logic [7:0]         l3, l0;

  adt7420_temp_proc #(.AVG_LOG2(3)) dut3 (
    .FSM_Clk(clk), .rst_n(rst_n), .temp_valid(temp_valid), .TempReg(TempReg),
    .clear(clear), .t_high(t_high), .t_hyst(t_hyst), .temp_c(c3), .temp_avg(a3),
    .temp_min(mn3), .temp_max(mx3), .sample_count(n3), .alarm(al3),
    .overrun(ov3), .out_valid(v3), .led(l3));

  adt7420_temp_proc #(.AVG_LOG2(0)) dut0 (
    .FSM_Clk(clk), .rst_n(rst_n), .temp_valid(temp_valid), .TempReg(TempReg),
    .clear(clear), .t_high(t_high), .t_hyst(t_hyst), .temp_c(c0), .temp_avg(a0),
    .temp_min(mn0), .temp_max(mx0), .sample_count(n0), .alarm(al0),
    .overrun(ov0), .out_valid(v0), .led(l0));

  int checks = 0;
  int failures = 0;

  // Reference model: plain integer arithmetic over sample windows.
  int m_c, m_min, m_max, m_cnt, m_ov, m_avg3, m_avg0, m_al3, m_al0;
  bit m_first;
  int q3[$];

  typedef struct {
    bit          clr;
    logic [15:0] tr;
    int c, a3, a0, mn, mx, cnt, al3, al0;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int to_temp(input logic [15:0] tr);
    int v;
    v = int'(tr) / 8;
    if (v >= 4096) v -= 8192;
    return v;
  endfunction

  function automatic int fdiv(input int s, input int d);
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  function automatic int next_alarm(input int cur, input int avg);
    if (avg > int'(t_high)) return 1;
    if (avg < int'(t_high) - int'(t_hyst)) return 0;
    return cur;
  endfunction

  task automatic model_clear();
    m_min = 4095; m_max = -4096; m_cnt = 0; m_ov = 0; m_first = 1;
  endtask

  task automatic model_reset();
    model_clear();
    m_c = 0; m_avg3 = 0; m_avg0 = 0; m_al3 = 0; m_al0 = 0;
    q3.delete();
  endtask

  task automatic model_sample(input logic [15:0] tr);
    int raw, s;
    raw = to_temp(tr);
    m_c = raw;
    if (m_first) begin
      q3.delete();
      for (int i = 0; i < 8; i++) q3.push_back(raw);
      m_first = 0;
    end else begin
      q3.push_back(raw);
      void'(q3.pop_front());
    end
    if (raw < m_min) m_min = raw;
    if (raw > m_max) m_max = raw;
    if (m_cnt < 65535) m_cnt++;
    s = 0;
    foreach (q3[i]) s += q3[i];
    m_avg3 = fdiv(s, 8);
    m_avg0 = raw;
    m_al3  = next_alarm(m_al3, m_avg3);
    m_al0  = next_alarm(m_al0, m_avg0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".temp_c3"}, int'(c3), m_c);
    chk({tag, ".temp_c0"}, int'(c0), m_c);
    chk({tag, ".avg3"}, int'(a3), m_avg3);
    chk({tag, ".avg0"}, int'(a0), m_avg0);
    chk({tag, ".min3"}, int'(mn3), m_min);
    chk({tag, ".max3"}, int'(mx3), m_max);
    chk({tag, ".min0"}, int'(mn0), m_min);
    chk({tag, ".max0"}, int'(mx0), m_max);
    chk({tag, ".count3"}, int'(n3), m_cnt);
    chk({tag, ".count0"}, int'(n0), m_cnt);
    chk({tag, ".alarm3"}, int'(al3), m_al3);
    chk({tag, ".alarm0"}, int'(al0), m_al0);
    chk({tag, ".overrun3"}, int'(ov3), m_ov);
    chk({tag, ".overrun0"}, int'(ov0), m_ov);
    chk({tag, ".led3"}, int'(l3), (m_avg3 >>> 4) & 255);
    chk({tag, ".led0"}, int'(l0), (m_avg0 >>> 4) & 255);
  endtask

  task automatic send(input logic [15:0] tr, input bit clr, input string tag);
    int n;
    @(negedge clk);
    TempReg = tr; temp_valid = 1'b1; clear = clr;
    if (clr) model_clear();
    model_sample(tr);
    @(negedge clk);
    temp_valid = 1'b0; clear = 1'b0;
    n = 1;
    while (!v3 && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, 3);
    chk({tag, ".out_valid0"}, int'(v0), 1);
    check_all(tag);
    @(negedge clk);
    chk({tag, ".out_valid_pulse"}, int'(v3), 0);
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    clear = 1'b1;
    model_clear();
    @(negedge clk);
    clear = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; temp_valid = 1'b0; clear = 1'b0; TempReg = '0;
    t_high = 13'sd480; t_hyst = 8'd16;
    model_reset();

    tbl[0] = '{1'b1, 16'h1900,  800,  800,  800,  800, 800, 1, 1, 1};
    tbl[1] = '{1'b0, 16'h0000,    0,  700,    0,    0, 800, 2, 1, 0};
    tbl[2] = '{1'b1, 16'hE700, -800, -800, -800, -800, -800, 1, 0, 0};
    tbl[3] = '{1'b1, 16'h0F80,  496,  496,  496,  496, 496, 1, 1, 1};
    tbl[4] = '{1'b0, 16'h0EB0,  470,  492,  470,  470, 496, 2, 1, 1};
    tbl[5] = '{1'b0, 16'h0E78,  463,  488,  463,  463, 496, 3, 1, 0};

    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.out_valid", int'(v3), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].tr, tbl[i].clr, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.c", i), int'(c3), tbl[i].c);
      chk($sformatf("tbl%0d.avg3", i), int'(a3), tbl[i].a3);
      chk($sformatf("tbl%0d.avg0", i), int'(a0), tbl[i].a0);
      chk($sformatf("tbl%0d.min", i), int'(mn3), tbl[i].mn);
      chk($sformatf("tbl%0d.max", i), int'(mx3), tbl[i].mx);
      chk($sformatf("tbl%0d.count", i), int'(n3), tbl[i].cnt);
      chk($sformatf("tbl%0d.alarm3", i), int'(al3), tbl[i].al3);
      chk($sformatf("tbl%0d.alarm0", i), int'(al0), tbl[i].al0);
      chk($sformatf("tbl%0d.led3", i), int'(l3), (tbl[i].a3 >>> 4) & 255);
    end

    // Back-to-back temp_valid: second pulse lands in UPDATE and is dropped.
    @(negedge clk);
    TempReg = 16'h0100; temp_valid = 1'b1;
    model_sample(16'h0100);
    @(negedge clk);
    TempReg = 16'h0200;
    m_ov = 1;
    @(negedge clk);
    temp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all("overrun");
    do_clear("overrun_clear");

    // Clear while in UPDATE: sample is latched into temp_c but never published.
    @(negedge clk);
    TempReg = 16'h3200; temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0; clear = 1'b1;
    m_c = to_temp(16'h3200);
    model_clear();
    @(negedge clk);
    clear = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (v3 || v0) seen = 1;
      @(negedge clk);
    end
    chk("clear_update.no_out_valid", seen, 0);
    check_all("clear_update");

    for (int i = 0; i < 150; i++) begin
      t_high = 13'($signed($urandom_range(0, 1200)) - 600);
      t_hyst = 8'($urandom_range(0, 255));
      send(16'($urandom), ($urandom_range(0, 15) == 0), $sformatf("rnd%0d", i));
    end

    // Async reset while the FSM sits in PUBLISH.
    @(negedge clk);
    TempReg = 16'h1900; temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_publish");
    chk("rst_publish.out_valid", int'(v3), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h1900, 1'b0, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
